// File: rtl/idex_stage_reg_pkg.sv
// Shared definitions for the ID->EX stage register: occupancy states and control-field layout.
package idex_stage_reg_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Bit offsets of the decoded control fields inside the CTRL_W payload
  localparam int unsigned CTRL_ALUSRC  = 0;
  localparam int unsigned CTRL_MEMRD   = 1;
  localparam int unsigned CTRL_MEMWR   = 2;
  localparam int unsigned CTRL_WBSEL   = 3;   // 2 bits
  localparam int unsigned CTRL_REGWR   = 5;
  localparam int unsigned CTRL_JALR    = 6;
  localparam int unsigned CTRL_JMP     = 7;
  localparam int unsigned CTRL_BRANCH  = 8;
  localparam int unsigned CTRL_ALUOP   = 9;   // 5 bits
  localparam int unsigned CTRL_FUNCT3  = 14;  // 3 bits
  localparam int unsigned CTRL_FUNCT7  = 17;  // 7 bits

endpackage

// File: rtl/idex_stage_reg_sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones until reset.
module idex_stage_reg_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/idex_stage_reg.sv
// ID->EX pipeline register with valid/ready handshake, optional skid entry and stall counter.
module idex_stage_reg
  import idex_stage_reg_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned CTRL_W = 24,
  parameter int unsigned TAG_W  = 15,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   in_ctrl,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [4*XLEN-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [TAG_W-1:0]    out_tag,
  output logic [4*XLEN-1:0]   out_data,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned DATA_W = 4 * XLEN;

  occ_e              state_q, state_d;
  logic              valid_q, valid_d;
  logic              rdy_q, rdy_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [TAG_W-1:0]  main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_fire, out_fire;

  // With the skid entry, ready comes straight from a flop; without it, ready looks through to EX
  assign in_ready = (SKID != 0) ? rdy_q : (~valid_q | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_tag_d  = main_tag_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_tag_d  = skid_tag_q;
    skid_data_d = skid_data_q;
    if (SKID != 0) begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_tag_d  = in_tag;
            main_data_d = in_data;
            state_d     = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (out_fire && in_fire) begin
            main_ctrl_d = in_ctrl;
            main_tag_d  = in_tag;
            main_data_d = in_data;
          end else if (out_fire) begin
            main_ctrl_d = '0;
            state_d     = OCC_EMPTY;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_tag_d  = in_tag;
            skid_data_d = in_data;
            state_d     = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_tag_d  = skid_tag_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            state_d     = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end else begin
      if (in_fire) begin
        main_ctrl_d = in_ctrl;
        main_tag_d  = in_tag;
        main_data_d = in_data;
        state_d     = OCC_ONE;
      end else if (out_fire) begin
        main_ctrl_d = '0;
        state_d     = OCC_EMPTY;
      end
    end
    // Redirect kills held entries and this cycle's input; tag/data are don't-care once invalid
    if (flush) begin
      state_d     = OCC_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end
  end

  assign valid_d = (state_d != OCC_EMPTY);
  assign rdy_d   = (state_d != OCC_FULL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= OCC_EMPTY;
      valid_q     <= 1'b0;
      rdy_q       <= 1'b1;
      main_ctrl_q <= '0;
      main_tag_q  <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_tag_q  <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rdy_q       <= rdy_d;
      main_ctrl_q <= main_ctrl_d;
      main_tag_q  <= main_tag_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_tag_q  <= skid_tag_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_tag   = main_tag_q;
  assign out_data  = main_data_q;

  idex_stage_reg_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (valid_q & ~out_ready),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg: skid build (CNT_W=4) and single-entry build side by side.
module tb_idex_stage_reg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned CTRL_W = 24;
  localparam int unsigned TAG_W  = 15;
  localparam int unsigned DATA_W = 4 * XLEN;

  logic              clk, rstn, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_data;

  logic              s_in_ready, s_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [TAG_W-1:0]  s_out_tag;
  logic [DATA_W-1:0] s_out_data;
  logic [3:0]        s_stall;

  logic              n_in_ready, n_out_valid;
  logic [CTRL_W-1:0] n_out_ctrl;
  logic [TAG_W-1:0]  n_out_tag;
  logic [DATA_W-1:0] n_out_data;
  logic [15:0]       n_stall;

  int n_cmp, n_err;

  idex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .TAG_W(TAG_W), .SKID(1), .CNT_W(4)) u_dut_skid (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_tag(in_tag), .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_tag(s_out_tag), .out_data(s_out_data),
    .stall_cnt(s_stall)
  );

  idex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .TAG_W(TAG_W), .SKID(0), .CNT_W(16)) u_dut_noskid (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_ctrl(in_ctrl), .in_tag(in_tag), .in_data(in_data), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_ctrl(n_out_ctrl), .out_tag(n_out_tag), .out_data(n_out_data),
    .stall_cnt(n_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CTRL_W-1:0] ctrl_of(input int n);
    return CTRL_W'(32'h00A5_0000 + n + 1);
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input int n);
    return TAG_W'(32'h1000 + n * 3);
  endfunction
  function automatic logic [DATA_W-1:0] data_of(input int n);
    return {64'hAAAA_0000_0000_0000 + 64'(n), 64'hBBBB_0000_0000_0000 + 64'(n),
            64'hCCCC_0000_0000_0000 + 64'(n), 64'hDDDD_0000_0000_0000 + 64'(n)};
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n);
    in_valid = 1'b1;
    in_ctrl  = ctrl_of(n);
    in_tag   = tag_of(n);
    in_data  = data_of(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head_s(input string tg, input int n);
    check({tg, "_s_valid"}, DATA_W'(s_out_valid), DATA_W'(1));
    check({tg, "_s_ctrl"},  DATA_W'(s_out_ctrl),  DATA_W'(ctrl_of(n)));
    check({tg, "_s_tag"},   DATA_W'(s_out_tag),   DATA_W'(tag_of(n)));
    check({tg, "_s_data"},  s_out_data,           data_of(n));
  endtask

  task automatic head_n(input string tg, input int n);
    check({tg, "_n_valid"}, DATA_W'(n_out_valid), DATA_W'(1));
    check({tg, "_n_ctrl"},  DATA_W'(n_out_ctrl),  DATA_W'(ctrl_of(n)));
    check({tg, "_n_data"},  n_out_data,           data_of(n));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_tag = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_valid", DATA_W'(s_out_valid), DATA_W'(0));
    check("rst_s_ready", DATA_W'(s_in_ready),  DATA_W'(1));
    check("rst_s_ctrl",  DATA_W'(s_out_ctrl),  DATA_W'(0));
    check("rst_s_tag",   DATA_W'(s_out_tag),   DATA_W'(0));
    check("rst_s_data",  s_out_data,           DATA_W'(0));
    check("rst_s_stall", DATA_W'(s_stall),     DATA_W'(0));
    check("rst_n_valid", DATA_W'(n_out_valid), DATA_W'(0));
    check("rst_n_ready", DATA_W'(n_in_ready),  DATA_W'(1));
    check("rst_n_stall", DATA_W'(n_stall),     DATA_W'(0));
    @(negedge clk) rstn = 1'b1;
    tick();

    // Streaming: one per cycle, one-cycle latency, no stalls
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(i);
      tick();
      head_s("stream", i);
      head_n("stream", i);
      check("stream_s_ready", DATA_W'(s_in_ready), DATA_W'(1));
    end
    in_valid = 1'b0;
    tick();
    check("drain_s_valid", DATA_W'(s_out_valid), DATA_W'(0));
    check("drain_s_ctrl",  DATA_W'(s_out_ctrl),  DATA_W'(0));
    check("drain_s_stall", DATA_W'(s_stall),     DATA_W'(0));

    // Back-pressure: A held, B in skid, C waits at ID
    out_ready = 1'b0;
    drive(10); tick();
    head_s("bp_a0", 10);
    drive(11); tick();
    head_s("bp_a1", 10);
    check("bp_full_ready", DATA_W'(s_in_ready), DATA_W'(0));
    drive(12); tick();
    head_s("bp_a2", 10);
    check("bp_full_ready2", DATA_W'(s_in_ready), DATA_W'(0));
    check("bp_stall", DATA_W'(s_stall), DATA_W'(2));
    out_ready = 1'b1;
    tick();
    head_s("bp_b", 11);
    check("bp_ready_back", DATA_W'(s_in_ready), DATA_W'(1));
    tick();
    head_s("bp_c", 12);
    in_valid = 1'b0;
    tick();
    check("bp_empty", DATA_W'(s_out_valid), DATA_W'(0));
    check("bp_stall_hold", DATA_W'(s_stall), DATA_W'(2));

    // Flush while FULL with D offered
    out_ready = 1'b0;
    drive(20); tick();
    drive(21); tick();
    check("fl_full_ready", DATA_W'(s_in_ready), DATA_W'(0));
    drive(23); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", DATA_W'(s_out_valid), DATA_W'(0));
    check("fl_ctrl",  DATA_W'(s_out_ctrl),  DATA_W'(0));
    check("fl_ready", DATA_W'(s_in_ready),  DATA_W'(1));
    out_ready = 1'b1;
    tick();
    check("fl_no_b", DATA_W'(s_out_valid), DATA_W'(0));
    drive(24); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_drop_in", DATA_W'(s_out_valid), DATA_W'(0));
    drive(25); tick();
    head_s("fl_recover", 25);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(30); tick();
    drive(31); tick();
    in_valid = 1'b0;
    check("ar_pre_ready", DATA_W'(s_in_ready), DATA_W'(0));
    #2 rstn = 1'b0;
    #1;
    check("ar_valid", DATA_W'(s_out_valid), DATA_W'(0));
    check("ar_ctrl",  DATA_W'(s_out_ctrl),  DATA_W'(0));
    check("ar_stall", DATA_W'(s_stall),     DATA_W'(0));
    check("ar_ready", DATA_W'(s_in_ready),  DATA_W'(1));
    @(negedge clk) rstn = 1'b1;
    tick();

    // Saturation of the 4-bit stall counter
    drive(40); tick();
    in_valid = 1'b0;
    head_s("sat_head", 40);
    check("sat_start", DATA_W'(s_stall), DATA_W'(0));
    repeat (14) tick();
    check("sat_14", DATA_W'(s_stall), DATA_W'(14));
    repeat (6) tick();
    check("sat_15", DATA_W'(s_stall), DATA_W'(15));
    head_s("sat_stable", 40);
    check("sat_n_cnt", DATA_W'(n_stall), DATA_W'(20));

    // Single-entry build: combinational ready, back-to-back loads
    head_n("ns_held", 40);
    check("ns_ready_blocked", DATA_W'(n_in_ready), DATA_W'(0));
    out_ready = 1'b1;
    #1;
    check("ns_ready_through", DATA_W'(n_in_ready), DATA_W'(1));
    drive(50); tick();
    head_n("ns_b2b0", 50);
    drive(51); tick();
    head_n("ns_b2b1", 51);
    in_valid = 1'b0;
    tick();
    check("ns_empty", DATA_W'(n_out_valid), DATA_W'(0));
    check("ns_ctrl0", DATA_W'(n_out_ctrl),  DATA_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
